// File: rtl/dcache_memresponder_if.sv
// Memory-port bundle between the dcache (master) and its memory responder (slave).
interface dcache_memresponder_if #(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 32
);
    logic [ADDRBITS-1:0] mem_addr;
    logic [DATABITS-1:0] mem_in;
    logic                mem_rdreq;
    logic                mem_wrreq;
    logic [DATABITS-1:0] mem_out;
    logic                mem_out_valid;
    logic [15:0]         mem_burstlen;
    logic                rd_overrun;

    modport master (
        output mem_addr, mem_in, mem_rdreq, mem_wrreq,
        input  mem_out, mem_out_valid, mem_burstlen, rd_overrun
    );

    modport slave (
        input  mem_addr, mem_in, mem_rdreq, mem_wrreq,
        output mem_out, mem_out_valid, mem_burstlen, rd_overrun
    );
endinterface

// File: rtl/dcache_memresponder.sv
// Word-addressed RAM that takes single-cycle writes and answers each read request
// with a fixed-length burst of consecutive words after a fixed latency.
module dcache_memresponder #(
    parameter int DATABITS    = 32,
    parameter int ADDRBITS    = 32,
    parameter int MEMADDRBITS = 10,
    parameter int BURSTLEN    = 8,
    parameter int READLATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dcache_memresponder_if.slave  bus
);
    localparam int DEPTH = 1 << MEMADDRBITS;
    localparam int LATW  = (READLATENCY > 1) ? $clog2(READLATENCY) : 1;

    typedef enum logic [1:0] {IDLE, LATENCY, BURST} state_t;

    state_t                 state;
    logic [MEMADDRBITS-1:0] idx;
    logic [MEMADDRBITS-1:0] rd_ptr;
    logic [LATW-1:0]        lat_cnt;
    logic [15:0]            burst_cnt;
    logic [DATABITS-1:0]    out_q;
    logic                   valid_q;
    logic                   overrun_q;
    logic [DATABITS-1:0]    ram [DEPTH];
    logic                   unused_addr;

    // Upper and byte-lane address bits are ignored, so the space aliases per word.
    assign idx         = bus.mem_addr[MEMADDRBITS+1:2];
    assign unused_addr = ^{bus.mem_addr[ADDRBITS-1:MEMADDRBITS+2], bus.mem_addr[1:0]};

    // NOTE: the RAM array is deliberately left out of reset; clearing thousands of
    // words needs a reset fan-out no block RAM supports, and contents must survive reset.
    always_ff @(posedge clk) begin
        if (bus.mem_wrreq)
            ram[idx] <= bus.mem_in;
    end

    // NOTE: all state here uses non-blocking assignments, so the burst read below
    // sees the RAM word from before a same-edge write (read-old-data).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            lat_cnt   <= '0;
            burst_cnt <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            out_q   <= '0;
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.mem_rdreq) begin
                        rd_ptr    <= idx;
                        lat_cnt   <= LATW'(READLATENCY - 1);
                        burst_cnt <= '0;
                        state     <= (READLATENCY > 1) ? LATENCY : BURST;
                    end
                end
                LATENCY: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LATW'(1))
                        state <= BURST;
                end
                BURST: begin
                    out_q     <= ram[rd_ptr];
                    valid_q   <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                    burst_cnt <= burst_cnt + 1'b1;
                    if (burst_cnt == 16'(BURSTLEN - 1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Requests outside IDLE are dropped but remembered until reset.
            if (bus.mem_rdreq && state != IDLE)
                overrun_q <= 1'b1;
        end
    end

    assign bus.mem_out       = out_q;
    assign bus.mem_out_valid = valid_q;
    assign bus.rd_overrun    = overrun_q;
    assign bus.mem_burstlen  = 16'(BURSTLEN);
endmodule

// File: tb/tb_dcache_memresponder.sv
// Randomised and directed bench for dcache_memresponder against a cycle-indexed burst model.
module tb_dcache_memresponder;
    localparam int DATABITS    = 32;
    localparam int ADDRBITS    = 32;
    localparam int MEMADDRBITS = 10;
    localparam int BURSTLEN    = 8;
    localparam int READLATENCY = 2;
    localparam int DEPTH       = 1 << MEMADDRBITS;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    dcache_memresponder_if #(.DATABITS(DATABITS), .ADDRBITS(ADDRBITS)) bus ();

    dcache_memresponder #(
        .DATABITS(DATABITS), .ADDRBITS(ADDRBITS), .MEMADDRBITS(MEMADDRBITS),
        .BURSTLEN(BURSTLEN), .READLATENCY(READLATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst accepted at edge T shows word k after edge T+READLATENCY+k,
    // and the responder is busy until edge T+READLATENCY+BURSTLEN.
    logic [31:0] model_mem [DEPTH];
    longint      edge_n      = 0;
    longint      next_free   = 0;
    longint      burst_start = 0;
    int          burst_base  = 0;
    bit          burst_on    = 0;
    logic [31:0] exp_out     = '0;
    logic        exp_valid   = 1'b0;
    logic        exp_ovr     = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_out   = '0;
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
            burst_on  = 0;
            next_free = 0;
        end else begin
            edge_n++;
            if (burst_on && edge_n >= burst_start && edge_n < burst_start + BURSTLEN) begin
                exp_valid = 1'b1;
                exp_out   = model_mem[(burst_base + int'(edge_n - burst_start)) % DEPTH];
            end else begin
                exp_valid = 1'b0;
                exp_out   = '0;
            end
            if (bus.mem_wrreq)
                model_mem[int'(bus.mem_addr[MEMADDRBITS+1:2])] = bus.mem_in;
            if (bus.mem_rdreq) begin
                if (edge_n >= next_free) begin
                    burst_on    = 1;
                    burst_start = edge_n + READLATENCY;
                    burst_base  = int'(bus.mem_addr[MEMADDRBITS+1:2]);
                    next_free   = edge_n + READLATENCY + BURSTLEN;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("mem_out", bus.mem_out, exp_out);
        check("mem_out_valid", {31'b0, bus.mem_out_valid}, {31'b0, exp_valid});
        check("rd_overrun", {31'b0, bus.rd_overrun}, {31'b0, exp_ovr});
        check("mem_burstlen", {16'b0, bus.mem_burstlen}, 32'd8);
    end

    logic [31:0] got [$];
    always @(negedge clk) begin
        if (bus.mem_out_valid === 1'b1)
            got.push_back(bus.mem_out);
    end

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.mem_rdreq = rd;
        bus.mem_wrreq = wr;
        bus.mem_addr  = a;
        bus.mem_in    = d;
        @(negedge clk);
        #1;
        bus.mem_rdreq = 1'b0;
        bus.mem_wrreq = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b0, $urandom, $urandom);
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_in    = '0;
        bus.mem_rdreq = 1'b0;
        bus.mem_wrreq = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Reset held: outputs quiet, requests have no effect.
        check("rst_mem_out", bus.mem_out, 32'h0);
        check("rst_valid", {31'b0, bus.mem_out_valid}, 32'h0);
        check("rst_overrun", {31'b0, bus.rd_overrun}, 32'h0);
        check("rst_burstlen", {16'b0, bus.mem_burstlen}, 32'd8);
        got.delete();
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        idle(1);
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        idle(12);
        check("rst_no_burst", got.size(), 32'd0);
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b1, 32'(i) << 2, $urandom);

        // Basic burst after back-to-back writes.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1));
        got.delete();
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        idle(14);
        check("t1_count", got.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t1_word%0d", i), got[i], 32'h11 * 32'(i + 1));
        check("t1_overrun", {31'b0, bus.rd_overrun}, 32'h0);

        // Second request during a burst is dropped and flagged.
        got.delete();
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        idle(2);
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        idle(20);
        check("t3_count", got.size(), 32'd8);
        check("t3_word7", got[7], 32'h88);
        check("t3_overrun", {31'b0, bus.rd_overrun}, 32'h1);

        // Wrap from the top of the RAM back to word 0, with aliased upper bits.
        for (int k = 0; k < 8; k++) begin
            int w;
            w = (1022 + k) % DEPTH;
            drive(1'b0, 1'b1, ($urandom & ~32'hFFF) | (32'(w) << 2), 32'hC0DE_0000 + 32'(w));
        end
        got.delete();
        drive(1'b1, 1'b0, 32'h0000_0FF8, 32'h0);
        idle(14);
        check("t4_count", got.size(), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("t4_word%0d", k), got[k], 32'hC0DE_0000 + 32'((1022 + k) % DEPTH));

        // Write to word 3 on the edge it is read: old data now, new data later.
        for (int i = 0; i < 8; i++)
            drive(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'h5000 + 32'(i));
        got.delete();
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        idle(READLATENCY + 2);
        drive(1'b0, 1'b1, 32'h20C, 32'hDEAD);
        idle(12);
        check("t5_old_word3", got[3], 32'h5003);
        got.delete();
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        idle(14);
        check("t5_new_word3", got[3], 32'hDEAD);
        check("t5_word4", got[4], 32'h5004);

        // Reset mid-burst aborts it; RAM survives.
        got.delete();
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 40 && got.size() < 4; i++)
            idle(1);
        check("t6_reach_word4", got.size(), 32'd4);
        #1 reset = 1'b1;
        #1;
        check("t6_valid_drop", {31'b0, bus.mem_out_valid}, 32'h0);
        check("t6_out_zero", bus.mem_out, 32'h0);
        check("t6_overrun_clr", {31'b0, bus.rd_overrun}, 32'h0);
        idle(4);
        reset = 1'b0;
        idle(8);
        check("t6_no_more_words", got.size(), 32'd4);
        got.delete();
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        idle(14);
        check("t6_post_count", got.size(), 32'd8);
        check("t6_post_word0", got[0], 32'h5000);
        check("t6_post_word3", got[3], 32'hDEAD);
        check("t6_post_word7", got[7], 32'h5007);

        // Random writes and non-overlapping bursts, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            logic rd;
            rd = (edge_n + 1 >= next_free) && ($urandom_range(3) == 0);
            drive(rd, 1'(($urandom_range(1))), $urandom, $urandom);
        end
        idle(20);
        check("rand_overrun", {31'b0, bus.rd_overrun}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_memresponder.md
Name: dcache_memresponder

Overview:
- Memory-side responder for the dcache memory port: the target that answers the cache's fill reads and flush writes.
- Holds a word-addressed RAM array that receives single-cycle word writes.
- Answers each read request with a fixed-length burst of consecutive words after a fixed latency.
- Used as the memory controller stand-in for simulation and FPGA bring-up of the dcache.

Parameters:
DATABITS, 32, data word width
ADDRBITS, 32, byte address width
MEMADDRBITS, 10, log2 of the RAM depth in words
BURSTLEN, 8, words returned per read request (1..65535)
READLATENCY, 2, cycles from the mem_rdreq sample to the first valid word (>=1)

Ports:
clk  input  1  clock, all logic on the rising edge
reset  input  1  asynchronous, active-high reset
mem_addr  input  ADDRBITS  byte address for a write, or the burst start for a read
mem_in  input  DATABITS  write data
mem_rdreq  input  1  read-burst request, sampled on a clk edge
mem_wrreq  input  1  single-word write request, sampled on a clk edge
mem_out  output  DATABITS  read data, registered
mem_out_valid  output  1  mem_out carries a burst word this cycle
mem_burstlen  output  16  constant BURSTLEN
rd_overrun  output  1  sticky flag: a read request arrived while a burst was in progress

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; mem_out=0; mem_out_valid=0; rd_overrun=0; counters=0.
  - RAM contents are not cleared.
- Word index = mem_addr[MEMADDRBITS+1:2].
  - Upper bits are ignored, so the address space aliases modulo 2^MEMADDRBITS words.
  - mem_addr[1:0] is ignored; every access is a full word.
- Writes:
  - mem_wrreq=1 at an edge writes mem_in to RAM[index] at that edge.
  - One word per cycle, back-to-back allowed, no acknowledge.
  - Writes are accepted in every state, including during a read burst.
- Read state machine, states IDLE, LATENCY, BURST:
  - IDLE: when mem_rdreq=1, latch rd_ptr=index and lat_cnt=READLATENCY-1.
    - Go to LATENCY if READLATENCY>1, otherwise go to BURST.
  - LATENCY: decrement lat_cnt each cycle; go to BURST when lat_cnt reaches 0.
  - BURST: each cycle, mem_out=RAM[rd_ptr] and mem_out_valid=1; rd_ptr+=1, wrapping at 2^MEMADDRBITS; burst_cnt+=1.
    - After BURSTLEN words, return to IDLE.
- Timing: with mem_rdreq sampled at edge T, the words for start, start+4, ... are valid in the BURSTLEN consecutive cycles following edges T+READLATENCY ... T+READLATENCY+BURSTLEN-1.
  - There are no gaps inside a burst.
- Next request:
  - A new mem_rdreq is accepted in IDLE only, including the edge on which the last burst word is presented; the state machine is IDLE at that edge.
  - The earliest back-to-back start is therefore the cycle after the final word.
- mem_rdreq while in LATENCY or BURST is ignored and sets rd_overrun=1, which stays set until reset.
- mem_out=0 whenever mem_out_valid=0.
- Read and write to the same word at the same edge: the read returns the old data. The write lands and is visible to later reads.
- mem_rdreq and mem_wrreq at the same edge: both are accepted, with the write applied as above.
- Reset mid-burst: the burst is aborted immediately and mem_out_valid drops asynchronously. The remaining words are never sent.

Test Plan:
1. Write 0x11,0x22,...,0x88 to byte addresses 0x100..0x11C (8 back-to-back wrreq). Then rdreq at 0x100 on edge T (BURSTLEN=8, READLATENCY=2) -> mem_out_valid high for exactly 8 cycles after edges T+2..T+9, with data 0x11..0x88 in order, and rd_overrun=0.
2. Hold reset; check outputs; pulse rdreq -> mem_out=0, mem_out_valid=0, rd_overrun=0, mem_burstlen=8, and no burst follows while reset is high.
3. rdreq at 0x100, then rdreq again 3 cycles later -> the first burst completes unchanged with exactly 8 valid words, no second burst starts, and rd_overrun=1 stays set.
4. MEMADDRBITS=10: preload words 1022,1023,0..5. rdreq at byte 0xFF8 -> words returned in order 1022,1023,0,1,2,3,4,5.
5. During a burst from 0x200, write 0xDEAD to 0x20C on the same edge that word 3 is read -> the burst returns the old word 3. A subsequent burst from 0x200 returns 0xDEAD at word 3.
6. Assert reset after the 4th valid word of a burst -> mem_out_valid=0 immediately with no further valid words. After release, rdreq works normally and RAM contents are preserved.
